// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the RGB332 to RGB444 pixel expansion.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FRONT  = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BACK   = 10'd48;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FRONT  = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BACK   = 10'd33;

  localparam logic [9:0] H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST  = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST  = V_TOTAL - 10'd1;

  // Sync windows are half-open: [START, END).
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Replicate MSBs so full-scale 3/2-bit channels map to full-scale 4-bit.
  function automatic logic [11:0] rgb332_to_444(input logic [7:0] pix);
    return {pix[7:5], pix[7], pix[4:2], pix[4], pix[1:0], pix[1:0]};
  endfunction

endpackage

// File: rtl/vga_pix_delay.sv
// Enable-gated shift register that delays the raw sync/active decode by PIPE_LAT pixel ticks.
module pix_delay #(
  parameter int W        = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (PIPE_LAT == 0) begin : g_pass
      logic unused_s;
      assign unused_s = ^{clk, rst, en, rst_val};
      assign q = d;
    end else begin : g_shift
      logic [W-1:0] stage_r [PIPE_LAT];

      // Shift one stage per pixel tick; every stage reloads rst_val on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            stage_r[i] <= rst_val;
          end
        end else if (en) begin
          stage_r[0] <= d;
          for (int i = 1; i < PIPE_LAT; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign q = stage_r[PIPE_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel divider, h/v counters, raw decode for the GPU,
// and a latency-matched RGB444/sync output register for the panel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_data,
  output logic [19:0] address,
  output logic        v_sync,
  output logic        pix_en,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [11:0] vga_rgb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic             pix_en_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             active_raw_s;
  logic             hs_raw_s;
  logic             vs_raw_s;
  logic [2:0]       dly_s;
  logic             vga_hs_r;
  logic             vga_vs_r;
  logic [11:0]      vga_rgb_r;

  assign pix_en_s = (div_cnt_r == DIV_LAST);
  assign h_wrap_s = (h_cnt_r == H_LAST);
  assign v_wrap_s = (v_cnt_r == V_LAST);

  // System-clock divider producing one pixel tick every CLK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (pix_en_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Horizontal/vertical position; line and frame wraps are decided from pre-update values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (pix_en_s) begin
      if (h_wrap_s) begin
        h_cnt_r <= 10'd0;
        v_cnt_r <= v_wrap_s ? 10'd0 : v_cnt_r + 10'd1;
      end else begin
        h_cnt_r <= h_cnt_r + 10'd1;
      end
    end
  end

  // Raw decode of the current position; syncs are active-low.
  always_comb begin
    active_raw_s = (h_cnt_r < H_ACTIVE) && (v_cnt_r < V_ACTIVE);
    hs_raw_s     = !((h_cnt_r >= H_SYNC_START) && (h_cnt_r < H_SYNC_END));
    vs_raw_s     = !((v_cnt_r >= V_SYNC_START) && (v_cnt_r < V_SYNC_END));
  end

  pix_delay #(
    .W        (3),
    .PIPE_LAT (PIPE_LAT)
  ) u_pix_delay (
    .clk     (clk),
    .rst     (rst),
    .en      (pix_en_s),
    .rst_val (3'b011),
    .d       ({active_raw_s, hs_raw_s, vs_raw_s}),
    .q       (dly_s)
  );

  // Panel output register: pixel_data arrives aligned with the delayed decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs_r  <= 1'b1;
      vga_vs_r  <= 1'b1;
      vga_rgb_r <= 12'h000;
    end else if (pix_en_s) begin
      vga_hs_r  <= dly_s[1];
      vga_vs_r  <= dly_s[0];
      vga_rgb_r <= dly_s[2] ? rgb332_to_444(pixel_data) : 12'h000;
    end
  end

  assign address     = {v_cnt_r, h_cnt_r};
  assign v_sync      = vs_raw_s;
  assign pix_en      = pix_en_s;
  assign frame_start = pix_en_s & h_wrap_s & v_wrap_s;
  assign vga_hs      = vga_hs_r;
  assign vga_vs      = vga_vs_r;
  assign vga_rgb     = vga_rgb_r;

endmodule
